// File: rtl/trace_pkg.sv
// trace_pkg: shared scheduler state type and tag constant (Tag state exists only with TRACE_TX_TAG_EN)
package trace_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
`ifdef TRACE_TX_TAG_EN
        ST_TAG,
`endif
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } tx_sched_state_t;
    localparam logic [3:0] TRACE_TAG_PREFIX = 4'hA;
endpackage

// File: rtl/trace_tx_sched_rr_arbiter.sv
// rr_arbiter: round-robin pick of the first request at or above the pointer, wrapping
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);
    int w_best;
    // Smallest upward distance from the pointer wins
    always_comb begin
        gnt_o  = '0;
        idx_o  = '0;
        w_best = N;
        for (int k = 0; k < N; k++) begin
            if (en_i && req_i[k] && ((k - int'(ptr_i) + N) % N) < w_best) begin
                w_best   = (k - int'(ptr_i) + N) % N;
                gnt_o    = '0;
                gnt_o[k] = 1'b1;
                idx_o    = IW'(k);
            end
        end
    end
endmodule

// File: rtl/trace_tx_sched.sv
// trace_tx_sched: round-robin trace byte scheduler feeding an external UART; TRACE_TX_TAG_EN prepends an id tag byte
module trace_tx_sched
    import trace_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [NUM_REQ*8-1:0] req_data_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [7:0]           tx_data_o,
    output logic                 tx_start_o,
    input  logic                 tx_done_i,
    output logic                 busy_o,
    output logic [ID_W-1:0]      grant_id_o
);
    tx_sched_state_t     r_state;
    logic [ID_W-1:0]     r_ptr, r_grant, w_idx, w_nxt;
    logic [NUM_REQ-1:0]  w_gnt;
    logic [7:0]          r_tx_data, w_byte;
    logic                w_en;
`ifdef TRACE_TX_TAG_EN
    logic [7:0]          r_byte;
    logic                r_pend;
`endif

    assign w_en        = rst_ni && r_state == ST_IDLE && tx_done_i;
    assign w_nxt       = ID_W'((int'(w_idx) + 1) % NUM_REQ);
    assign req_ready_o = w_gnt;
    assign tx_data_o   = r_tx_data;
    assign tx_start_o  = r_state == ST_START;
    assign busy_o      = r_state != ST_IDLE;
    assign grant_id_o  = r_grant;

    rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
        .req_i (req_valid_i),
        .ptr_i (r_ptr),
        .en_i  (w_en),
        .gnt_o (w_gnt),
        .idx_o (w_idx)
    );

    // Winner's byte lane, zero when nobody is granted
    always_comb begin
        w_byte = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (w_gnt[k]) w_byte = req_data_i[k*8 +: 8];
    end

    // Scheduler FSM; tx_data only changes on edges entering Start so it stays stable between strobes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_tx_data <= '0;
`ifdef TRACE_TX_TAG_EN
            r_byte    <= '0;
            r_pend    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: if (|w_gnt) begin
                    r_grant <= w_idx;
                    r_ptr   <= w_nxt;
`ifdef TRACE_TX_TAG_EN
                    r_byte  <= w_byte;
                    r_pend  <= 1'b1;
                    r_state <= ST_TAG;
`else
                    r_tx_data <= w_byte;
                    r_state   <= ST_START;
`endif
                end
`ifdef TRACE_TX_TAG_EN
                ST_TAG: begin
                    r_tx_data <= {TRACE_TAG_PREFIX, 4'(r_grant)};
                    r_state   <= ST_START;
                end
`endif
                ST_START:     r_state <= ST_WAIT_BUSY;
                ST_WAIT_BUSY: if (!tx_done_i) r_state <= ST_WAIT_DONE;
                ST_WAIT_DONE: if (tx_done_i) begin
`ifdef TRACE_TX_TAG_EN
                    if (r_pend) begin
                        r_pend    <= 1'b0;
                        r_tx_data <= r_byte;
                        r_state   <= ST_START;
                    end else
`endif
                    r_state <= ST_IDLE;
                end
                default:      r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
